// File: rtl/hbm_init_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hbm_init_seq_pkg
//  Description : Shared types and width constants for the HBM bring-up and
//                health sequencer.
//  Contents    : state_e     - sequencer state encoding (exported on o_state)
//                err_cause_e - latched failure cause (exported on o_err_cause)
//  Revision    : 1.0 - initial release
// ============================================================================
package hbm_init_seq_pkg;

    localparam int c_STATE_W = 3;
    localparam int c_ERR_W   = 2;
    localparam int c_TEMP_W  = 3;

    typedef enum logic [c_STATE_W-1:0] {
        IDLE       = 3'd0,
        RST_ASSERT = 3'd1,
        WAIT_CAL   = 3'd2,
        READY      = 3'd3,
        FAIL       = 3'd4,
        TRIP       = 3'd5
    } state_e;

    typedef enum logic [c_ERR_W-1:0] {
        ERR_NONE     = 2'd0,
        ERR_CAL_FAIL = 2'd1,
        ERR_TIMEOUT  = 2'd2,
        ERR_LOST     = 2'd3
    } err_cause_e;

endpackage
`default_nettype wire

// File: rtl/hbm_init_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hbm_init_seq_ctrl
//  Description : Bring-up and health sequencer for the HBM subsystem. Pulses
//                the device resets, waits for calibration with a per-attempt
//                timeout and bounded retry, latches failure cause / devices,
//                and traps on catastrophic temperature.
//  Ports       : clk, reset          fabric clock, synchronous active-high reset
//                i_start             begin a sequence from IDLE
//                i_clear_err         leave FAIL, clearing error status
//                i_cal_success/fail  per-device calibration status
//                i_cattrip           per-device catastrophic-temperature trip
//                i_temp              packed 3-bit per-device temperature codes
//                o_hbm_rst_n         per-device HBM reset (active-low)
//                o_app_rst_n         AFU channel reset (active-low)
//                o_ready             subsystem calibrated and usable
//                o_state             current state_e
//                o_err_cause         err_cause_e of last terminal failure
//                o_fail_dev_mask     devices implicated in last failure
//                o_retry_cnt         retries consumed
//                o_temp_alarm        registered temp >= TEMP_ALARM_THRESH
//  Revision    : 1.0 - initial release
// ============================================================================
module hbm_init_seq_ctrl
    import hbm_init_seq_pkg::*;
#(
    parameter int                     NUM_DEVICES        = 2,
    parameter logic [NUM_DEVICES-1:0] DEV_EN             = '1,
    parameter int                     RST_PULSE_CYCLES   = 16,
    parameter int                     CAL_TIMEOUT_CYCLES = 2**24,
    parameter int                     MAX_RETRIES        = 3,
    parameter logic [2:0]             TEMP_ALARM_THRESH  = 3'd6
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            i_start,
    input  logic                            i_clear_err,
    input  logic [NUM_DEVICES-1:0]          i_cal_success,
    input  logic [NUM_DEVICES-1:0]          i_cal_fail,
    input  logic [NUM_DEVICES-1:0]          i_cattrip,
    input  logic [c_TEMP_W*NUM_DEVICES-1:0] i_temp,
    output logic [NUM_DEVICES-1:0]          o_hbm_rst_n,
    output logic                            o_app_rst_n,
    output logic                            o_ready,
    output logic [c_STATE_W-1:0]            o_state,
    output logic [c_ERR_W-1:0]              o_err_cause,
    output logic [NUM_DEVICES-1:0]          o_fail_dev_mask,
    output logic [(MAX_RETRIES > 0 ? $clog2(MAX_RETRIES+1) : 1)-1:0] o_retry_cnt,
    output logic [NUM_DEVICES-1:0]          o_temp_alarm
);

    localparam int c_RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam int c_CNT_MAX = (RST_PULSE_CYCLES > CAL_TIMEOUT_CYCLES) ?
                               RST_PULSE_CYCLES : CAL_TIMEOUT_CYCLES;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    localparam logic [c_CNT_W-1:0]   c_PULSE_LOAD = c_CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0]   c_TO_LAST    = c_CNT_W'(CAL_TIMEOUT_CYCLES - 1);
    localparam logic [c_RETRY_W-1:0] c_RETRY_MAX  = c_RETRY_W'(MAX_RETRIES);

    state_e                 r_state, w_next;
    logic [c_CNT_W-1:0]     r_cnt, w_cnt_nxt;
    logic [c_RETRY_W-1:0]   r_retry, w_retry_nxt;
    err_cause_e             r_err, w_err_nxt;
    logic [NUM_DEVICES-1:0] r_mask, w_mask_nxt;
    logic [NUM_DEVICES-1:0] r_hbm_rst_n;
    logic                   r_app_rst_n;
    logic                   r_ready;
    logic [NUM_DEVICES-1:0] r_temp_alarm;

    logic                   w_trip;
    logic                   w_fail_any;
    logic                   w_all_ok;
    logic                   w_timeout;
    logic [NUM_DEVICES-1:0] w_not_ok;
    logic [NUM_DEVICES-1:0] w_temp_hot;

    assign w_trip     = |(i_cattrip & DEV_EN);
    assign w_fail_any = |(i_cal_fail & DEV_EN);
    assign w_not_ok   = ~i_cal_success & DEV_EN;
    assign w_all_ok   = (w_not_ok == '0);
    assign w_timeout  = (r_cnt == c_TO_LAST);

    // Next-state / status decode. The single counter counts down through the
    // reset pulse and up through the calibration window.
    always_comb begin
        w_next      = r_state;
        w_cnt_nxt   = r_cnt;
        w_retry_nxt = r_retry;
        w_err_nxt   = r_err;
        w_mask_nxt  = r_mask;

        if (w_trip) begin
            w_next = TRIP;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        w_next    = RST_ASSERT;
                        w_cnt_nxt = c_PULSE_LOAD;
                    end
                end
                RST_ASSERT: begin
                    if (r_cnt == '0) begin
                        w_next    = WAIT_CAL;
                        w_cnt_nxt = '0;
                    end else begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end
                end
                WAIT_CAL: begin
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (w_fail_any || w_timeout) begin
                        if (r_retry < c_RETRY_MAX) begin
                            w_retry_nxt = r_retry + 1'b1;
                            w_next      = RST_ASSERT;
                            w_cnt_nxt   = c_PULSE_LOAD;
                        end else begin
                            w_next     = FAIL;
                            w_err_nxt  = w_fail_any ? ERR_CAL_FAIL : ERR_TIMEOUT;
                            w_mask_nxt = w_fail_any ? (i_cal_fail & DEV_EN) : w_not_ok;
                        end
                    end else if (w_all_ok) begin
                        w_next = READY;
                    end
                end
                READY: begin
                    // All enabled devices were high on entry, so any low one
                    // here is a device that has dropped calibration.
                    if (!w_all_ok) begin
                        w_next     = FAIL;
                        w_err_nxt  = ERR_LOST;
                        w_mask_nxt = w_not_ok;
                    end
                end
                FAIL: begin
                    if (i_clear_err) begin
                        w_next      = IDLE;
                        w_err_nxt   = ERR_NONE;
                        w_mask_nxt  = '0;
                        w_retry_nxt = '0;
                    end
                end
                TRIP:    w_next = TRIP;
                default: w_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_retry     <= '0;
            r_err       <= ERR_NONE;
            r_mask      <= '0;
            r_hbm_rst_n <= '0;
            r_app_rst_n <= 1'b0;
            r_ready     <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_cnt       <= w_cnt_nxt;
            r_retry     <= w_retry_nxt;
            r_err       <= w_err_nxt;
            r_mask      <= w_mask_nxt;
            // Reset outputs are decoded from the next state so they move on
            // the same edge as o_state.
            r_hbm_rst_n <= (w_next == WAIT_CAL || w_next == READY) ? DEV_EN : '0;
            r_app_rst_n <= (w_next == READY);
            r_ready     <= (w_next == READY);
        end
    end

    for (genvar gi = 0; gi < NUM_DEVICES; gi++) begin : g_temp_hot
        assign w_temp_hot[gi] = DEV_EN[gi] &&
                                (i_temp[gi*c_TEMP_W +: c_TEMP_W] >= TEMP_ALARM_THRESH);
    end

    always_ff @(posedge clk) begin
        if (reset) r_temp_alarm <= '0;
        else       r_temp_alarm <= w_temp_hot;
    end

    assign o_hbm_rst_n     = r_hbm_rst_n;
    assign o_app_rst_n     = r_app_rst_n;
    assign o_ready         = r_ready;
    assign o_state         = r_state;
    assign o_err_cause     = r_err;
    assign o_fail_dev_mask = r_mask;
    assign o_retry_cnt     = r_retry;
    assign o_temp_alarm    = r_temp_alarm;

endmodule
`default_nettype wire

// File: tb/tb_hbm_init_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hbm_init_seq_ctrl
//  Description : Directed self-checking bench for hbm_init_seq_ctrl. A second
//                instance with only device 0 enabled shares the stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hbm_init_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start, clear_err;
    logic [1:0] cal_success, cal_fail, cattrip;
    logic [5:0] temp;

    logic [1:0] hbm_rst_n, fail_dev_mask, retry_cnt, temp_alarm, err_cause;
    logic       app_rst_n, ready;
    logic [2:0] state;

    logic [1:0] b_hbm_rst_n, b_fail_dev_mask, b_retry_cnt, b_temp_alarm, b_err_cause;
    logic       b_app_rst_n, b_ready;
    logic [2:0] b_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hbm_init_seq_ctrl #(
        .NUM_DEVICES(2), .DEV_EN(2'b11), .RST_PULSE_CYCLES(4),
        .CAL_TIMEOUT_CYCLES(100), .MAX_RETRIES(2), .TEMP_ALARM_THRESH(3'd6)
    ) dut (
        .clk(clk), .reset(reset), .i_start(start), .i_clear_err(clear_err),
        .i_cal_success(cal_success), .i_cal_fail(cal_fail), .i_cattrip(cattrip),
        .i_temp(temp), .o_hbm_rst_n(hbm_rst_n), .o_app_rst_n(app_rst_n),
        .o_ready(ready), .o_state(state), .o_err_cause(err_cause),
        .o_fail_dev_mask(fail_dev_mask), .o_retry_cnt(retry_cnt),
        .o_temp_alarm(temp_alarm)
    );

    hbm_init_seq_ctrl #(
        .NUM_DEVICES(2), .DEV_EN(2'b01), .RST_PULSE_CYCLES(4),
        .CAL_TIMEOUT_CYCLES(100), .MAX_RETRIES(2), .TEMP_ALARM_THRESH(3'd6)
    ) dut_b (
        .clk(clk), .reset(reset), .i_start(start), .i_clear_err(clear_err),
        .i_cal_success(cal_success), .i_cal_fail(cal_fail), .i_cattrip(cattrip),
        .i_temp(temp), .o_hbm_rst_n(b_hbm_rst_n), .o_app_rst_n(b_app_rst_n),
        .o_ready(b_ready), .o_state(b_state), .o_err_cause(b_err_cause),
        .o_fail_dev_mask(b_fail_dev_mask), .o_retry_cnt(b_retry_cnt),
        .o_temp_alarm(b_temp_alarm)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; clear_err = 1'b0;
        cal_success = 2'b00; cal_fail = 2'b00; cattrip = 2'b00; temp = 6'd0;
        tick(); tick();
        reset = 1'b0;
    endtask

    // Start a sequence and wait (bounded) for the main DUT to reach WAIT_CAL.
    task automatic reach_wait(output bit ok);
        int cyc;
        start = 1'b1; tick(); start = 1'b0;
        cyc = 0;
        while (state != 3'd2 && cyc < 50) begin tick(); cyc++; end
        ok = (state == 3'd2);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL rst_state: got %0d want 0", state); end
        checks++; if (hbm_rst_n !== 2'b00 || app_rst_n !== 1'b0 || ready !== 1'b0) begin
            errors++; $display("FAIL rst_resets: got hbm=%b app=%b rdy=%b want 00 0 0", hbm_rst_n, app_rst_n, ready); end
        checks++; if (err_cause !== 2'd0 || fail_dev_mask !== 2'b00 || retry_cnt !== 2'd0 || temp_alarm !== 2'b00) begin
            errors++; $display("FAIL rst_status: got err=%0d mask=%b retry=%0d alarm=%b want 0 00 0 00",
                               err_cause, fail_dev_mask, retry_cnt, temp_alarm); end
    endtask

    task automatic test_bringup();
        int n_rst, cyc;
        do_reset();
        start = 1'b1; tick(); start = 1'b0;
        checks++; if (state !== 3'd1 || hbm_rst_n !== 2'b00) begin
            errors++; $display("FAIL t1_rst_entry: got state=%0d hbm=%b want 1 00", state, hbm_rst_n); end
        n_rst = 0; cyc = 0;
        while (state == 3'd1 && cyc < 50) begin n_rst++; tick(); cyc++; end
        checks++; if (n_rst !== 4) begin errors++; $display("FAIL t1_pulse_len: got %0d want 4", n_rst); end
        checks++; if (state !== 3'd2 || hbm_rst_n !== 2'b11 || app_rst_n !== 1'b0) begin
            errors++; $display("FAIL t1_wait_entry: got state=%0d hbm=%b app=%b want 2 11 0", state, hbm_rst_n, app_rst_n); end
        repeat (9) tick();
        cal_success = 2'b11;
        checks++; if (state !== 3'd2 || ready !== 1'b0) begin
            errors++; $display("FAIL t1_still_wait: got state=%0d rdy=%b want 2 0", state, ready); end
        tick();
        checks++; if (state !== 3'd3 || app_rst_n !== 1'b1 || ready !== 1'b1 || retry_cnt !== 2'd0) begin
            errors++; $display("FAIL t1_ready: got state=%0d app=%b rdy=%b retry=%0d want 3 1 1 0",
                               state, app_rst_n, ready, retry_cnt); end
    endtask

    task automatic test_retry();
        bit ok;
        int n_rst, cyc;
        do_reset();
        reach_wait(ok);
        checks++; if (!ok) begin errors++; $display("FAIL t2_reach_wait: got state=%0d want 2", state); end
        cal_fail = 2'b10; tick(); cal_fail = 2'b00;
        checks++; if (state !== 3'd1 || retry_cnt !== 2'd1 || hbm_rst_n !== 2'b00) begin
            errors++; $display("FAIL t2_retry: got state=%0d retry=%0d hbm=%b want 1 1 00", state, retry_cnt, hbm_rst_n); end
        n_rst = 0; cyc = 0;
        while (state == 3'd1 && cyc < 50) begin n_rst++; tick(); cyc++; end
        checks++; if (n_rst !== 4 || state !== 3'd2) begin
            errors++; $display("FAIL t2_pulse2: got len=%0d state=%0d want 4 2", n_rst, state); end
        cal_success = 2'b11; tick();
        checks++; if (state !== 3'd3 || retry_cnt !== 2'd1 || err_cause !== 2'd0) begin
            errors++; $display("FAIL t2_ready: got state=%0d retry=%0d err=%0d want 3 1 0", state, retry_cnt, err_cause); end
    endtask

    task automatic test_timeout();
        int n_rst, n_wait, cyc;
        do_reset();
        start = 1'b1; tick(); start = 1'b0;
        n_rst = 0; n_wait = 0; cyc = 0;
        while (state != 3'd4 && cyc < 1000) begin
            if (state == 3'd1) n_rst++;
            if (state == 3'd2) n_wait++;
            tick(); cyc++;
        end
        checks++; if (n_rst !== 12 || n_wait !== 300) begin
            errors++; $display("FAIL t3_attempts: got rst=%0d wait=%0d want 12 300", n_rst, n_wait); end
        checks++; if (state !== 3'd4 || err_cause !== 2'd2 || fail_dev_mask !== 2'b11 || retry_cnt !== 2'd2) begin
            errors++; $display("FAIL t3_fail: got state=%0d err=%0d mask=%b retry=%0d want 4 2 11 2",
                               state, err_cause, fail_dev_mask, retry_cnt); end
        checks++; if (hbm_rst_n !== 2'b00 || app_rst_n !== 1'b0) begin
            errors++; $display("FAIL t3_fail_resets: got hbm=%b app=%b want 00 0", hbm_rst_n, app_rst_n); end
        clear_err = 1'b1; tick(); clear_err = 1'b0;
        checks++; if (state !== 3'd0 || err_cause !== 2'd0 || fail_dev_mask !== 2'b00 || retry_cnt !== 2'd0) begin
            errors++; $display("FAIL t3_clear: got state=%0d err=%0d mask=%b retry=%0d want 0 0 00 0",
                               state, err_cause, fail_dev_mask, retry_cnt); end
    endtask

    task automatic test_cattrip();
        bit ok;
        do_reset();
        reach_wait(ok);
        cal_success = 2'b11; tick();
        checks++; if (!ok || state !== 3'd3) begin errors++; $display("FAIL t4_ready: got state=%0d want 3", state); end
        cattrip = 2'b01; tick(); cattrip = 2'b00;
        checks++; if (state !== 3'd5 || hbm_rst_n !== 2'b00 || app_rst_n !== 1'b0 || ready !== 1'b0) begin
            errors++; $display("FAIL t4_trip: got state=%0d hbm=%b app=%b rdy=%b want 5 00 0 0",
                               state, hbm_rst_n, app_rst_n, ready); end
        clear_err = 1'b1; start = 1'b1; tick(); tick(); clear_err = 1'b0; start = 1'b0;
        checks++; if (state !== 3'd5) begin errors++; $display("FAIL t4_sticky: got state=%0d want 5", state); end
        reset = 1'b1; tick(); reset = 1'b0;
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL t4_reset_exit: got state=%0d want 0", state); end
    endtask

    task automatic test_lost_and_priority();
        bit ok;
        do_reset();
        reach_wait(ok);
        cal_success = 2'b11; tick();
        cal_success = 2'b01; tick();
        checks++; if (state !== 3'd4 || err_cause !== 2'd3 || fail_dev_mask !== 2'b10 || ready !== 1'b0) begin
            errors++; $display("FAIL t5_lost: got state=%0d err=%0d mask=%b rdy=%b want 4 3 10 0",
                               state, err_cause, fail_dev_mask, ready); end
        do_reset();
        reach_wait(ok);
        cal_fail = 2'b01; cal_success = 2'b11; tick(); cal_fail = 2'b00;
        checks++; if (!ok || state !== 3'd1 || retry_cnt !== 2'd1 || ready !== 1'b0) begin
            errors++; $display("FAIL t5_fail_wins: got state=%0d retry=%0d rdy=%b want 1 1 0", state, retry_cnt, ready); end
    endtask

    task automatic test_reset_mid_and_temp();
        bit ok;
        do_reset();
        reach_wait(ok);
        temp = {3'd5, 3'd7};
        reset = 1'b1; tick();
        checks++; if (state !== 3'd0 || hbm_rst_n !== 2'b00 || app_rst_n !== 1'b0 || ready !== 1'b0 ||
                      err_cause !== 2'd0 || fail_dev_mask !== 2'b00 || retry_cnt !== 2'd0 || temp_alarm !== 2'b00) begin
            errors++; $display("FAIL t6_mid_reset: got state=%0d hbm=%b app=%b rdy=%b alarm=%b want 0 00 0 0 00",
                               state, hbm_rst_n, app_rst_n, ready, temp_alarm); end
        reset = 1'b0; tick();
        checks++; if (temp_alarm !== 2'b01) begin errors++; $display("FAIL t6_alarm_57: got %b want 01", temp_alarm); end
        temp = {3'd6, 3'd5}; tick();
        checks++; if (temp_alarm !== 2'b10) begin errors++; $display("FAIL t6_alarm_thresh: got %b want 10", temp_alarm); end
        temp = {3'd7, 3'd7}; tick();
        checks++; if (temp_alarm !== 2'b11 || b_temp_alarm !== 2'b01) begin
            errors++; $display("FAIL t6_alarm_dev_en: got %b/%b want 11/01", temp_alarm, b_temp_alarm); end
        do_reset();
        reach_wait(ok);
        checks++; if (b_state !== 3'd2 || b_hbm_rst_n !== 2'b01) begin
            errors++; $display("FAIL t6_b_wait: got state=%0d hbm=%b want 2 01", b_state, b_hbm_rst_n); end
        cal_success = 2'b01; cal_fail = 2'b10; tick(); cal_fail = 2'b00;
        checks++; if (b_state !== 3'd3 || b_app_rst_n !== 1'b1 || b_hbm_rst_n !== 2'b01 || state !== 3'd1) begin
            errors++; $display("FAIL t6_b_ready: got b_state=%0d b_app=%b b_hbm=%b state=%0d want 3 1 01 1",
                               b_state, b_app_rst_n, b_hbm_rst_n, state); end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; clear_err = 1'b0;
        cal_success = 2'b00; cal_fail = 2'b00; cattrip = 2'b00; temp = 6'd0;
        test_reset();
        test_bringup();
        test_retry();
        test_timeout();
        test_cattrip();
        test_lost_and_priority();
        test_reset_mid_and_temp();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
